// File: rtl/mux_select_scheduler_if.sv
// Handshake and data bundle between the 4:1 byte mux, its scheduler and the downstream consumer.
interface mux_select_scheduler_if #(parameter int q = 7);
  logic [3:0] req;
  logic [1:0] select;
  logic [q:0] mux_out;
  logic [q:0] data_out;
  logic       valid;
  logic       ready;
  logic [3:0] ack;

  modport master (
    input  req, mux_out, ready,
    output select, data_out, valid, ack
  );

  modport slave (
    output req, mux_out, ready,
    input  select, data_out, valid, ack
  );
endinterface

// File: rtl/mux_select_scheduler.sv
// Arbitrates four request lines onto the mux select, waits one settle cycle, captures and hands off the byte.
// Build option: define SCHED_FIXED_PRIORITY_EN for fixed 0>1>2>3 priority instead of round-robin.
module mux_select_scheduler #(
  parameter int q = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_select_scheduler_if.master bus
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETTLE = 2'b01;
  localparam logic [1:0] SEND   = 2'b10;

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] select_q;
  logic [1:0] winner;
  logic [q:0] data_q;
  logic       valid_q;
  logic [3:0] ack_q;

  assign bus.select   = select_q;
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.ack      = ack_q;

  // Loops run from lowest to highest priority so the last hit is the winner.
  always_comb begin
    // NOTE: default assignment first so every path drives winner and no latch is inferred.
    winner = last;
`ifdef SCHED_FIXED_PRIORITY_EN
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) winner = 2'(i);
    end
`else
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[last + 2'(k)]) winner = last + 2'(k);
    end
`endif
  end

  // select_q still holds the granted channel during SETTLE, so it doubles as the winner there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 2'b11;
      select_q <= 2'b00;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (|bus.req) begin
            select_q <= winner;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          data_q  <= bus.mux_out;
          valid_q <= 1'b1;
          ack_q   <= 4'b0001 << select_q;
          last    <= select_q;
          state   <= SEND;
        end
        SEND: begin
          ack_q <= 4'b0000;
          if (bus.ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          ack_q   <= 4'b0000;
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_scheduler.sv
// Self-checking bench: transaction-level arbiter model feeds a scoreboard, a negedge monitor checks the DUT.
module tb_mux_select_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [7:0] chan [4];

  mux_select_scheduler_if #(.q(7)) bus ();
  mux_select_scheduler #(.q(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.mux_out = chan[bus.select];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: first requesting channel after the previous grant, or lowest index when fixed.
  function automatic logic [1:0] pick(input logic [3:0] r, input int prev);
`ifdef SCHED_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
`else
    for (int k = 1; k <= 4; k++) if (r[(prev + k) % 4]) return 2'((prev + k) % 4);
`endif
    return 2'(prev);
  endfunction

  // Transaction model: a grant is taken when idle with requests, one settle cycle, then wait for ready.
  int m_phase = 0;
  int m_last = 3;
  int m_win = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_last  = 3;
      sb.delete();
    end else begin
      case (m_phase)
        0: if (bus.req != 0) begin
             m_win = int'(pick(bus.req, m_last));
             sb.push_back('{ch: 2'(m_win), data: chan[m_win]});
             m_phase = 1;
           end
        1: begin
             m_last  = m_win;
             m_phase = 2;
           end
        default: if (bus.ready) m_phase = 0;
      endcase
    end
  end

  // Monitor: valid must match the model phase; each ack pulse consumes one expected grant.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("valid_vs_model", bus.valid, m_phase == 2);
      if (bus.ack != 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got %b expected no pulse (t=%0t)", bus.ack, $time);
        end else begin
          e = sb.pop_front();
          check("sb_ack", bus.ack, 4'b0001 << e.ch);
          check("sb_data", bus.data_out, e.data);
          check("sb_select", bus.select, e.ch);
          check("sb_valid", bus.valid, 1);
        end
      end
    end
  end

  task automatic wait_ack(output logic [3:0] a, output int c);
    a = '0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack != 0) begin
        a = bus.ack;
        c = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_timeout: got no ack expected a pulse within 20 cycles (t=%0t)", $time);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    int c, prev_c;
    logic [7:0] hold_data;
    logic [1:0] hold_sel;
    logic [1:0] exp_ch;

    bus.req   = '0;
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) chan[i] = 8'($urandom);

    #12;
    check("rst_valid", bus.valid, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_select", bus.select, 0);
    check("rst_data", bus.data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single request on channel C.
    chan[2] = 8'h5A;
    @(negedge clk);
    bus.req = 4'b0100;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    check("single_select", bus.select, 2'b10);
    check("single_no_valid_yet", bus.valid, 0);
    @(posedge clk); #1;
    check("single_data", bus.data_out, 8'h5A);
    check("single_valid", bus.valid, 1);
    check("single_ack", bus.ack, 4'b0100);
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    check("single_valid_drop", bus.valid, 0);
    check("single_ack_drop", bus.ack, 0);

    // Request withdrawn during SETTLE still completes.
    @(negedge clk);
    bus.req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    check("withdraw_ack", bus.ack, 4'b0010);
    check("withdraw_data", bus.data_out, chan[1]);
    @(posedge clk); #1;
    check("withdraw_done", bus.valid, 0);
    repeat (2) @(posedge clk);
    #1;
    check("withdraw_idle_valid", bus.valid, 0);
    check("withdraw_idle_ack", bus.ack, 0);

    // Backpressure: hold for five cycles, then accept.
    @(negedge clk);
    bus.ready = 1'b0;
    bus.req = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    check("bp_valid", bus.valid, 1);
    hold_data = bus.data_out;
    hold_sel  = bus.select;
    check("bp_sel", hold_sel, 2'b11);
    @(negedge clk);
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", bus.valid, 1);
      check("bp_hold_data", bus.data_out, hold_data);
      check("bp_hold_sel", bus.select, hold_sel);
      check("bp_hold_ack", bus.ack, 0);
    end
    @(negedge clk);
    bus.ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", bus.valid, 0);

    // Asynchronous reset in the middle of SEND.
    @(negedge clk);
    bus.ready = 1'b0;
    bus.req = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check("mid_send_valid", bus.valid, 1);
    @(negedge clk);
    bus.req = '0;
    #1;
    rst = 1'b1;
    #1;
    check("async_valid", bus.valid, 0);
    check("async_ack", bus.ack, 0);
    check("async_select", bus.select, 0);
    check("async_data", bus.data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // All four requesting with ready high: grants three cycles apart.
    @(negedge clk);
    bus.ready = 1'b1;
    bus.req = 4'b1111;
    prev_c = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, c);
`ifdef SCHED_FIXED_PRIORITY_EN
      exp_ch = 2'd0;
`else
      exp_ch = 2'(k % 4);
`endif
      check("rr_order", a, 4'b0001 << exp_ch);
      if (k > 0) check("rr_spacing", c - prev_c, 3);
      prev_c = c;
    end
    pulse_reset();

    // Alternate pattern B and D from a fresh reset.
    @(negedge clk);
    bus.req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a, c);
`ifdef SCHED_FIXED_PRIORITY_EN
      exp_ch = 2'd1;
`else
      exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
`endif
      check("bd_order", a, 4'b0001 << exp_ch);
    end
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);

    // Random traffic: the monitor and scoreboard do the checking.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.req   = 4'($urandom);
      bus.ready = ($urandom_range(0, 3) != 0);
      if (i % 50 == 0 && bus.valid == 0 && m_phase == 0) begin
        bus.req = '0;
        for (int j = 0; j < 4; j++) chan[j] = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.req = '0;
    bus.ready = 1'b1;
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("end_valid", bus.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
